// File: rtl/fir_decim_multi.sv
// rtl/fir_decim_multi.sv - lockstep multi-channel decimating FIR with one shared multiplier
//
// Filters NUM_CHANNELS sample streams with one coefficient set. All channels
// are read together, filtered one tap per cycle through a single multiplier,
// and written together, so the outputs stay sample-aligned.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   x_in_dout    packed input samples, channel c at [c*DATA_SIZE +: DATA_SIZE]
//   x_in_empty   per-channel upstream FIFO empty
//   x_in_rd_en   per-channel upstream FIFO read strobe (all-or-none)
//   y_out_din    packed filter results, same layout as x_in_dout
//   y_out_full   per-channel downstream FIFO full
//   y_out_wr_en  per-channel downstream FIFO write strobe (all-or-none)

module fir_decim_multi #(
   parameter int NUM_CHANNELS = 2,
   parameter int DATA_SIZE    = 32,
   parameter int BITS         = 10,
   parameter int NUM_TAPS     = 32,
   parameter int DECIMATION   = 8,
   parameter logic signed [0:NUM_TAPS-1][DATA_SIZE-1:0] COEFFICIENTS = '0
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_CHANNELS*DATA_SIZE-1:0] x_in_dout,
   input  logic [NUM_CHANNELS-1:0]           x_in_empty,
   output logic [NUM_CHANNELS-1:0]           x_in_rd_en,
   output logic [NUM_CHANNELS*DATA_SIZE-1:0] y_out_din,
   input  logic [NUM_CHANNELS-1:0]           y_out_full,
   output logic [NUM_CHANNELS-1:0]           y_out_wr_en
);

   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int TW = $clog2(NUM_TAPS);
   localparam int DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam int PW = 2 * DATA_SIZE;
   // Added to negative products before the arithmetic shift so the
   // division by 2^BITS truncates toward zero instead of toward -inf.
   localparam logic signed [PW-1:0] ROUND_BIAS = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

   typedef enum logic [1:0] {S_SHIFT, S_MAC, S_WRITE} state_t;

   state_t state, next_state;

   logic [DATA_SIZE-1:0]              hist [NUM_CHANNELS][NUM_TAPS];
   logic [DATA_SIZE-1:0]              acc  [NUM_CHANNELS];
   logic [NUM_CHANNELS*DATA_SIZE-1:0] acc_flat;
   logic [NUM_CHANNELS*DATA_SIZE-1:0] dout_q;
   logic [DW-1:0]                     sample_cnt;
   logic [TW-1:0]                     tap_idx;
   logic [CW-1:0]                     ch_idx;
   logic [TW-1:0]                     coef_idx;
   logic                              rd_all;
   logic                              last_read;
   logic                              last_mac;
   logic                              write_now;
   logic signed [PW-1:0]              product;
   logic signed [PW-1:0]              biased;
   logic [DATA_SIZE-1:0]              acc_inc;

   // Reset also gates the read strobe so nothing is popped while held in reset.
   assign rd_all    = reset && (state == S_SHIFT) && (x_in_empty == '0);
   assign last_read = rd_all && (sample_cnt == DW'(DECIMATION - 1));
   assign last_mac  = (state == S_MAC) && (tap_idx == TW'(NUM_TAPS - 1))
                      && (ch_idx == CW'(NUM_CHANNELS - 1));
   assign write_now = (state == S_WRITE) && (y_out_full == '0);

   // Newest sample x[c][0] pairs with the last coefficient.
   assign coef_idx = TW'(NUM_TAPS - 1) - tap_idx;
   assign product  = PW'($signed(hist[ch_idx][tap_idx])) * PW'($signed(COEFFICIENTS[coef_idx]));
   assign biased   = product + (product[PW-1] ? ROUND_BIAS : '0);
   assign acc_inc  = DATA_SIZE'(biased >>> BITS);

   always_comb begin
      acc_flat = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         acc_flat[c*DATA_SIZE +: DATA_SIZE] = acc[c];
      end
   end

   // The result register only follows acc on the write cycle, so the output
   // bus stays stable while the next group is being accumulated.
   assign y_out_din = (state == S_WRITE) ? acc_flat : dout_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_SHIFT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      x_in_rd_en  = '0;
      y_out_wr_en = '0;
      case (state)
         S_SHIFT: begin
            x_in_rd_en = {NUM_CHANNELS{rd_all}};
            if (last_read) begin
               next_state = S_MAC;
            end
         end
         S_MAC: begin
            if (last_mac) begin
               next_state = S_WRITE;
            end
         end
         S_WRITE: begin
            if (write_now) begin
               y_out_wr_en = '1;
               next_state  = S_SHIFT;
            end
         end
         default: next_state = S_SHIFT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            acc[c] <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
               hist[c][i] <= '0;
            end
         end
         dout_q     <= '0;
         sample_cnt <= '0;
         tap_idx    <= '0;
         ch_idx     <= '0;
      end else begin
         if (rd_all) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               for (int i = NUM_TAPS - 1; i > 0; i--) begin
                  hist[c][i] <= hist[c][i-1];
               end
               hist[c][0] <= x_in_dout[c*DATA_SIZE +: DATA_SIZE];
            end
            if (last_read) begin
               sample_cnt <= '0;
               for (int c = 0; c < NUM_CHANNELS; c++) begin
                  acc[c] <= '0;
               end
            end else begin
               sample_cnt <= sample_cnt + DW'(1);
            end
         end

         if (state == S_MAC) begin
            acc[ch_idx] <= acc[ch_idx] + acc_inc;
            if (tap_idx == TW'(NUM_TAPS - 1)) begin
               tap_idx <= '0;
               ch_idx  <= (ch_idx == CW'(NUM_CHANNELS - 1)) ? '0 : ch_idx + CW'(1);
            end else begin
               tap_idx <= tap_idx + TW'(1);
            end
         end

         if (write_now) begin
            dout_q <= acc_flat;
         end
      end
   end

endmodule

// File: tb/tb_fir_decim_multi.sv
// tb/tb_fir_decim_multi.sv - self-checking bench for fir_decim_multi (D=1 and D=2 instances)

module tb_fir_decim_multi;

   localparam int C = 2;
   localparam int W = 32;
   localparam int N = 4;
   localparam int B = 10;
   localparam logic signed [0:N-1][W-1:0] H_PK = {32'd1, 32'd2, 32'd3, 32'd4};

   int H   [N] = '{1, 2, 3, 4};
   int DEC [2] = '{1, 2};

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [C-1:0]   rd_en [2];
   logic [C-1:0]   wr_en [2];
   logic [C-1:0]   empty_in [2];
   logic [C-1:0]   hold [2];
   logic [C-1:0]   full_in [2];
   logic [C*W-1:0] xdout [2];
   logic [C*W-1:0] ydin [2];

   // Upstream FIFO model: mem holds every sample ever pushed, in order.
   logic [C*W-1:0] mem [2][0:1023];
   int wp [2];
   int rp [2]     = '{0, 0};
   int oc [2]     = '{0, 0};
   int rd_cnt [2] = '{0, 0};
   int viol [2]   = '{0, 0};
   int last_rd [2] = '{0, 0};
   int base [2];
   int ocb [2];
   int cyc = 0;
   bit pop [2];
   logic [C*W-1:0] outv [2][0:511];
   int lat [2][0:511];

   int n_cmp;
   int n_fail;

   assign xdout[0]    = mem[0][rp[0][9:0]];
   assign xdout[1]    = mem[1][rp[1][9:0]];
   assign empty_in[0] = {C{wp[0] == rp[0]}} | hold[0];
   assign empty_in[1] = {C{wp[1] == rp[1]}} | hold[1];

   fir_decim_multi #(.NUM_CHANNELS(C), .DATA_SIZE(W), .BITS(B), .NUM_TAPS(N),
                     .DECIMATION(1), .COEFFICIENTS(H_PK)) dut_d1 (
      .clock(clock), .reset(reset),
      .x_in_dout(xdout[0]), .x_in_empty(empty_in[0]), .x_in_rd_en(rd_en[0]),
      .y_out_din(ydin[0]), .y_out_full(full_in[0]), .y_out_wr_en(wr_en[0]));

   fir_decim_multi #(.NUM_CHANNELS(C), .DATA_SIZE(W), .BITS(B), .NUM_TAPS(N),
                     .DECIMATION(2), .COEFFICIENTS(H_PK)) dut_d2 (
      .clock(clock), .reset(reset),
      .x_in_dout(xdout[1]), .x_in_empty(empty_in[1]), .x_in_rd_en(rd_en[1]),
      .y_out_din(ydin[1]), .y_out_full(full_in[1]), .y_out_wr_en(wr_en[1]));

   // Observe strobes mid-cycle; the FIFO pop takes effect on the following edge.
   always @(negedge clock) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         pop[k] = 1'b0;
         if (rd_en[k] != '0) begin
            if (rd_en[k] != '1 || (rd_en[k] & empty_in[k]) != '0) viol[k]++;
            pop[k] = 1'b1;
            rd_cnt[k]++;
            last_rd[k] = cyc;
         end
         if (wr_en[k] != '0) begin
            if (wr_en[k] != '1 || full_in[k] != '0) viol[k]++;
            outv[k][oc[k]] = ydin[k];
            lat[k][oc[k]]  = cyc - last_rd[k];
            oc[k]++;
         end
      end
   end

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (pop[k]) rp[k] <= rp[k] + 1;
      end
   end

   // Reference: output j uses the D*(j-ocb+1) newest samples since the last
   // reset; each product is divided by 2^B toward zero, sum wraps to W bits.
   function automatic logic [W-1:0] ref_y(int k, int j, int c);
      longint acc;
      longint s;
      int newest;
      logic [C*W-1:0] v;
      acc = 0;
      newest = base[k] + (j - ocb[k] + 1) * DEC[k] - 1;
      for (int i = 0; i < N; i++) begin
         if (newest - i >= base[k]) begin
            v   = mem[k][newest - i];
            s   = longint'($signed(v[c*W +: W]));
            acc = acc + (s * longint'(H[N-1-i])) / (longint'(1) << B);
         end
      end
      return acc[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd();
      return W'($urandom_range(0, 2097151)) - 32'd1048576;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(int k, logic [W-1:0] s0, logic [W-1:0] s1);
      mem[k][wp[k]] = {s1, s0};
      wp[k]++;
   endtask

   task automatic wait_oc(int k, int target, int budget);
      for (int t = 0; t < budget && oc[k] < target; t++) tick();
   endtask

   task automatic wait_rd(int k, int r0, int budget);
      for (int t = 0; t < budget && rd_cnt[k] == r0; t++) tick();
   endtask

   task automatic test_reset();
      push(0, 32'd1024, 32'd0);
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (rd_en[k] !== '0) begin n_fail++; $display("FAIL reset_rd_en dut%0d: got %b want 0", k, rd_en[k]); end
         n_cmp++; if (wr_en[k] !== '0) begin n_fail++; $display("FAIL reset_wr_en dut%0d: got %b want 0", k, wr_en[k]); end
         n_cmp++; if (ydin[k] !== '0) begin n_fail++; $display("FAIL reset_dout dut%0d: got %h want 0", k, ydin[k]); end
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_impulse_d1();
      int st;
      logic [W-1:0] got, exp;
      st = oc[0];
      repeat (7) push(0, 32'd0, 32'd0);
      wait_oc(0, st + 8, 300);
      n_cmp++; if (oc[0] !== st + 8) begin n_fail++; $display("FAIL imp1_count: got %0d want %0d", oc[0] - st, 8); end
      for (int j = st; j < oc[0]; j++) begin
         exp = (j - st < 4) ? W'(4 - (j - st)) : '0;
         got = outv[0][j][W-1:0];
         n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL imp1_ch0 out%0d: got %0d want %0d", j, $signed(got), $signed(exp)); end
         got = outv[0][j][2*W-1:W];
         n_cmp++; if (got !== '0) begin n_fail++; $display("FAIL imp1_ch1 out%0d: got %0d want 0", j, $signed(got)); end
         n_cmp++; if (lat[0][j] !== 9) begin n_fail++; $display("FAIL imp1_latency out%0d: got %0d want 9", j, lat[0][j]); end
      end
   endtask

   task automatic test_impulse_d2();
      int st;
      int want [3] = '{3, 1, 0};
      logic [W-1:0] got;
      st = oc[1];
      push(1, 32'd1024, 32'd0);
      repeat (5) push(1, 32'd0, 32'd0);
      wait_oc(1, st + 3, 200);
      repeat (40) tick();
      n_cmp++; if (oc[1] !== st + 3) begin n_fail++; $display("FAIL imp2_count: got %0d want 3", oc[1] - st); end
      for (int j = 0; j < 3 && st + j < oc[1]; j++) begin
         got = outv[1][st+j][W-1:0];
         n_cmp++; if (got !== W'(want[j])) begin n_fail++; $display("FAIL imp2_ch0 out%0d: got %0d want %0d", j, $signed(got), want[j]); end
         got = outv[1][st+j][2*W-1:W];
         n_cmp++; if (got !== '0) begin n_fail++; $display("FAIL imp2_ch1 out%0d: got %0d want 0", j, $signed(got)); end
      end
   endtask

   task automatic test_truncation();
      int st;
      logic [W-1:0] got, exp;
      st = oc[0];
      repeat (4) push(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      push(0, 32'hFFFF_F800, 32'd5);
      repeat (3) push(0, 32'd0, 32'd0);
      wait_oc(0, st + 8, 300);
      n_cmp++; if (oc[0] !== st + 8) begin n_fail++; $display("FAIL trunc_count: got %0d want 8", oc[0] - st); end
      if (oc[0] > st + 4) begin
         got = outv[0][st+4][W-1:0];
         n_cmp++; if (got !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL trunc_neg2048: got %0d want -8", $signed(got)); end
      end
      for (int j = st; j < oc[0]; j++) begin
         for (int c = 0; c < C; c++) begin
            exp = ref_y(0, j, c);
            got = outv[0][j][c*W +: W];
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL trunc out%0d ch%0d: got %0d want %0d", j, c, $signed(got), $signed(exp)); end
         end
      end
   endtask

   task automatic test_lockstep_stall();
      int st, r0, r1;
      logic [W-1:0] got, exp;
      st = oc[1];
      r0 = rd_cnt[1];
      push(1, rnd(), rnd());
      wait_rd(1, r0, 50);
      n_cmp++; if (rd_cnt[1] !== r0 + 1) begin n_fail++; $display("FAIL stall_first_read: got %0d want %0d", rd_cnt[1] - r0, 1); end
      hold[1] = 2'b10;
      repeat (5) push(1, rnd(), rnd());
      r1 = rd_cnt[1];
      repeat (20) tick();
      n_cmp++; if (rd_cnt[1] !== r1) begin n_fail++; $display("FAIL stall_reads_during_hold: got %0d want 0", rd_cnt[1] - r1); end
      hold[1] = 2'b00;
      wait_oc(1, st + 3, 300);
      n_cmp++; if (oc[1] !== st + 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", oc[1] - st); end
      for (int j = st; j < oc[1]; j++) begin
         for (int c = 0; c < C; c++) begin
            exp = ref_y(1, j, c);
            got = outv[1][j][c*W +: W];
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL stall out%0d ch%0d: got %0d want %0d", j, c, $signed(got), $signed(exp)); end
         end
      end
   endtask

   task automatic test_backpressure();
      int st, r0, r1, w0;
      logic [W-1:0] got, exp;
      st = oc[0];
      r0 = rd_cnt[0];
      push(0, rnd(), rnd());
      wait_rd(0, r0, 50);
      n_cmp++; if (rd_cnt[0] !== r0 + 1) begin n_fail++; $display("FAIL bp_first_read: got %0d want 1", rd_cnt[0] - r0); end
      repeat (3) tick();
      full_in[0] = 2'b01;
      repeat (3) push(0, rnd(), rnd());
      w0 = oc[0];
      r1 = rd_cnt[0];
      repeat (50) tick();
      n_cmp++; if (oc[0] !== w0) begin n_fail++; $display("FAIL bp_writes_while_full: got %0d want 0", oc[0] - w0); end
      n_cmp++; if (rd_cnt[0] !== r1) begin n_fail++; $display("FAIL bp_reads_while_full: got %0d want 0", rd_cnt[0] - r1); end
      full_in[0] = 2'b00;
      wait_oc(0, st + 4, 200);
      n_cmp++; if (oc[0] !== st + 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", oc[0] - st); end
      for (int j = st; j < oc[0]; j++) begin
         for (int c = 0; c < C; c++) begin
            exp = ref_y(0, j, c);
            got = outv[0][j][c*W +: W];
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL bp out%0d ch%0d: got %0d want %0d", j, c, $signed(got), $signed(exp)); end
         end
      end
   endtask

   task automatic test_random();
      int st, pushed;
      logic [W-1:0] got, exp;
      st = oc[0];
      pushed = 0;
      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            push(0, ($urandom_range(0, 7) == 0) ? W'($urandom) : rnd(), rnd());
            pushed++;
         end
         hold[0]    = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 3)) : '0;
         full_in[0] = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 3)) : '0;
         tick();
      end
      hold[0]    = '0;
      full_in[0] = '0;
      wait_oc(0, st + pushed, 2500);
      n_cmp++; if (oc[0] !== st + pushed) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", oc[0] - st, pushed); end
      for (int j = st; j < oc[0]; j++) begin
         for (int c = 0; c < C; c++) begin
            exp = ref_y(0, j, c);
            got = outv[0][j][c*W +: W];
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rand out%0d ch%0d: got %0d want %0d", j, c, $signed(got), $signed(exp)); end
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (viol[k] !== 0) begin n_fail++; $display("FAIL handshake_violations dut%0d: got %0d want 0", k, viol[k]); end
      end
   endtask

   task automatic test_reset_mid_mac();
      int st, r0;
      logic [W-1:0] got, exp;
      r0 = rd_cnt[0];
      push(0, 32'd1024, 32'd0);
      wait_rd(0, r0, 50);
      n_cmp++; if (rd_cnt[0] !== r0 + 1) begin n_fail++; $display("FAIL rst_first_read: got %0d want 1", rd_cnt[0] - r0); end
      tick();
      tick();
      #1;
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (rd_en[k] !== '0) begin n_fail++; $display("FAIL rst_mid_rd_en dut%0d: got %b want 0", k, rd_en[k]); end
         n_cmp++; if (wr_en[k] !== '0) begin n_fail++; $display("FAIL rst_mid_wr_en dut%0d: got %b want 0", k, wr_en[k]); end
         n_cmp++; if (ydin[k] !== '0) begin n_fail++; $display("FAIL rst_mid_dout dut%0d: got %h want 0", k, ydin[k]); end
         base[k] = rp[k];
         ocb[k]  = oc[k];
      end
      repeat (3) tick();
      reset = 1'b1;
      st = oc[0];
      push(0, 32'd1024, 32'd0);
      repeat (3) push(0, 32'd0, 32'd0);
      wait_oc(0, st + 4, 200);
      n_cmp++; if (oc[0] !== st + 4) begin n_fail++; $display("FAIL rst_count: got %0d want 4", oc[0] - st); end
      if (oc[0] > st) begin
         got = outv[0][st][W-1:0];
         n_cmp++; if (got !== 32'd4) begin n_fail++; $display("FAIL rst_first_output: got %0d want 4", $signed(got)); end
      end
      for (int j = st; j < oc[0]; j++) begin
         for (int c = 0; c < C; c++) begin
            exp = ref_y(0, j, c);
            got = outv[0][j][c*W +: W];
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rst out%0d ch%0d: got %0d want %0d", j, c, $signed(got), $signed(exp)); end
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         hold[k]    = '0;
         full_in[k] = '0;
         wp[k]      = 0;
         base[k]    = 0;
         ocb[k]     = 0;
      end
      test_reset();
      test_impulse_d1();
      test_impulse_d2();
      test_truncation();
      test_lockstep_stall();
      test_backpressure();
      test_random();
      test_reset_mid_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_decim_multi.md
Name: fir_decim_multi

Overview:
- Parametrised successor to the single-channel decimating FIR used in the FM receiver audio path.
- Filters NUM_CHANNELS sample streams in lockstep with one shared coefficient set and one time-shared multiplier, for example the LPR and LMR paths together, so their outputs stay sample-aligned for the downstream add/sub stage.
- Reads from upstream FIFOs and writes to downstream FIFOs using the standard rd_en/empty and wr_en/full handshakes.

Parameters:
- NUM_CHANNELS, 2, number of lockstep streams (1..8).
- DATA_SIZE, 32, sample and coefficient width; signed two's complement.
- BITS, 10, fixed-point fraction bits used for dequantisation.
- NUM_TAPS, 32, filter length (>=2).
- DECIMATION, 8, input samples consumed per output (>=1).
- COEFFICIENTS, all zero, signed [0:NUM_TAPS-1][DATA_SIZE-1:0] tap array h.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- x_in_dout  in  NUM_CHANNELS*DATA_SIZE  channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
- x_in_empty  in  NUM_CHANNELS  per-channel upstream FIFO empty.
- x_in_rd_en  out  NUM_CHANNELS  per-channel upstream FIFO read strobe.
- y_out_din  out  NUM_CHANNELS*DATA_SIZE  packed per-channel results, same layout as x_in_dout.
- y_out_full  in  NUM_CHANNELS  per-channel downstream FIFO full.
- y_out_wr_en  out  NUM_CHANNELS  per-channel downstream FIFO write strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_SHIFT; all history registers, accumulators, sample counter, tap index and channel index = 0.
  - x_in_rd_en, y_out_wr_en and y_out_din = 0.
  - Reset mid-MAC or mid-write drops the partial result; no write occurs after reset is released until a full DECIMATION group has been read.
- Input reads (combinational gating):
  - In S_SHIFT, x_in_rd_en = all ones iff every bit of x_in_empty is 0; otherwise all zeros.
  - Channels are never read individually.
- Sample acceptance:
  - On each cycle where x_in_rd_en is all ones, each channel's history shifts by one: x[c][i] <= x[c][i-1], and x[c][0] <= the channel's x_in_dout.
  - The sample counter increments on each such cycle.
  - When the counter reaches DECIMATION-1 on a read cycle, the counter clears and the next state is S_MAC.
- S_MAC:
  - One multiply per cycle, iterating channel-major: c = 0..NUM_CHANNELS-1, then i = 0..NUM_TAPS-1 within each channel.
  - p = x[c][i] * h[NUM_TAPS-1-i], held at full 2*DATA_SIZE precision.
  - acc[c] += p / 2^BITS, using signed division that truncates toward zero (not an arithmetic shift). Accumulation is DATA_SIZE-bit modulo (wraps).
  - The accumulator is cleared at the start of each output.
  - Duration is exactly NUM_CHANNELS*NUM_TAPS cycles, then S_WRITE.
  - No input reads occur in S_MAC or S_WRITE.
- S_WRITE:
  - Waits while any bit of y_out_full is 1; stalls indefinitely with no data loss.
  - When no channel is full: y_out_wr_en = all ones for exactly one cycle, y_out_din = acc, then S_SHIFT.
  - Writes are all-channels-or-none.
  - y_out_din holds its last value outside S_WRITE; y_out_wr_en = 0 outside S_WRITE.
- Latency:
  - With no stalls, the write strobe asserts NUM_CHANNELS*NUM_TAPS+1 cycles after the cycle of the last read of the group.
  - Sustained throughput is one output per DECIMATION + NUM_CHANNELS*NUM_TAPS + 1 cycles.
- Output history:
  - y[c][n] = sum over i of h[NUM_TAPS-1-i]*x[c][i], dequantised per product, where x[c][0] is the newest sample.
  - History persists across outputs; only reset clears it.
- Boundary conditions:
  - x_in_empty deasserting mid-group: reading resumes with the counter preserved.
  - y_out_full toggling during S_MAC has no effect.
  - DECIMATION=1: every read triggers an S_MAC pass.
  - NUM_CHANNELS=1 behaves identically to the single-channel FIR.

Test Plan:
- Impulse, DECIMATION=1 (NUM_CHANNELS=2, NUM_TAPS=4, BITS=10, h={1,2,3,4}):
  - Stimulus: ch0 gets 1024 then zeros; ch1 gets all zeros.
  - Required: ch0 outputs 4,3,2,1,0,0…; ch1 outputs all 0.
  - Each y_out_wr_en pulse is 9 cycles after its read.
- Impulse, DECIMATION=2, same h:
  - Stimulus: ch0 gets 1024,0,0,0,0,0.
  - Required: ch0 outputs 3,1,0; exactly 3 write pulses.
- Truncation: x=-1, h={0,0,0,1}, DECIMATION=1:
  - Required: output 0 (not -1).
  - With x=-2048: output -2.
- Lockstep and stall:
  - Hold x_in_empty[1]=1 for 20 cycles while ch0 has data.
  - Required: no rd_en on either channel during the hold; results identical to the unstalled run.
- Backpressure:
  - Assert y_out_full[0] for 50 cycles during S_WRITE.
  - Required: no wr_en on any channel during the stall; a single write afterwards with the correct values; no read until that write completes.
- Reset mid-operation:
  - Assert reset during the 3rd MAC cycle.
  - Required: all outputs 0 immediately; after release, the first output equals a fresh-start impulse response (4 for the impulse case).
